// File: rtl/sd_cmd_sender.sv
// SD CMD-line transmitter: CRC7 load/wait handshake, then a 48-bit frame sent MSB-first, one bit per clk.
// Defining SD_CMD_NCC_EN adds an 8-cycle GAP after each frame, keeping the line idle for N_CC.
module sd_cmd_sender #(
  parameter int unsigned CRC_TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        crc_load,
  output logic [39:0] crc_data,
  input  logic        crc_ready,
  input  logic [6:0]  crc_in,
  output logic        sd_cmd_out,
  output logic        sd_cmd_oe,
  output logic        done,
  output logic        crc_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_SEND,
    S_DONE
`ifdef SD_CMD_NCC_EN
    , S_GAP
`endif
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(CRC_TIMEOUT);
  localparam logic [7:0] GAP_LAST    = 8'd7;

  state_t      state_q, state_d;
  logic [39:0] crc_data_q, crc_data_d;
  logic [47:0] frame_q, frame_d;
  logic [5:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        crc_err_q, crc_err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      crc_data_q <= '0;
      frame_q    <= '0;
      bitcnt_q   <= '0;
      cnt_q      <= '0;
      crc_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      crc_data_q <= crc_data_d;
      frame_q    <= frame_d;
      bitcnt_q   <= bitcnt_d;
      cnt_q      <= cnt_d;
      crc_err_q  <= crc_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    crc_data_d = crc_data_q;
    frame_d    = frame_q;
    bitcnt_d   = bitcnt_q;
    cnt_d      = cnt_q;
    crc_err_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          crc_data_d = {2'b01, cmd_index, cmd_arg};
          state_d    = S_LOAD;
        end
      end
      // crc_ready may still be high from the previous command, so it is not looked at here
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (crc_ready) begin
          frame_d  = {crc_data_q, crc_in, 1'b1};
          bitcnt_d = 6'd47;
          state_d  = S_SEND;
        end else if (cnt_d == TIMEOUT_CNT) begin
          crc_err_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_SEND: begin
        if (bitcnt_q == 6'd0) begin
          state_d = S_DONE;
        end else begin
          bitcnt_d = bitcnt_q - 6'd1;
        end
      end
      S_DONE: begin
`ifdef SD_CMD_NCC_EN
        cnt_d   = '0;
        state_d = S_GAP;
`else
        state_d = S_IDLE;
`endif
      end
`ifdef SD_CMD_NCC_EN
      S_GAP: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign crc_load   = (state_q == S_LOAD);
  assign crc_data   = crc_data_q;
  assign sd_cmd_oe  = (state_q == S_SEND);
  assign sd_cmd_out = (state_q == S_SEND) ? frame_q[bitcnt_q] : 1'b1;
  assign done       = (state_q == S_DONE);
  assign crc_err    = crc_err_q;

endmodule
